display_mode_sequencer: RTL and testbench

Sequencer in front of the display output. It measures incoming video timing (active width and line count) frame by frame against the expected format. It debounces good and bad frames and decides between live video and the fail-safe test pattern. It drives the pattern generator's start input and selects which source reaches the panel, switching only on frame boundaries.

---
 rtl/display_mode_sequencer_pkg.sv | 21 ++
 rtl/display_mode_sequencer_frame_timing_meter.sv | 93 +++++++++
 rtl/display_mode_sequencer.sv | 170 +++++++++++++++++
 tb/tb_display_mode_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_mode_sequencer_pkg.sv
// Shared state encoding and counter widths for the display mode sequencer.
package display_mode_sequencer_pkg;

  localparam int WCNT_W = 12;
  localparam int LCNT_W = 11;
  localparam int FCNT_W = 4;
  localparam int WD_W   = 24;

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = '1;
  localparam logic [WD_W-1:0]   WD_MAX   = '1;

  typedef enum logic [1:0] {
    ST_ACQUIRE   = 2'd0,
    ST_LIVE      = 2'd1,
    ST_FS_WAIT   = 2'd2,
    ST_FAILSAFE  = 2'd3
  } state_e;

endpackage

// File: rtl/display_mode_sequencer_frame_timing_meter.sv
// Measures active width and line count of the live source frame by frame and
// reports a frame_end/frame_good pulse pair plus per-frame error flags.
module frame_timing_meter
  import display_mode_sequencer_pkg::*;
#(
  parameter logic [WCNT_W-1:0] ACTIVE_WIDTH = 12'd1920,
  parameter logic [LCNT_W-1:0] LINE_NUM     = 11'd1080
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_en_i,
  input  logic v_sync_i,
  output logic frame_end_o,
  output logic frame_good_o,
  output logic width_high_err_o,
  output logic width_low_err_o,
  output logic line_high_err_o,
  output logic line_low_err_o
);

  logic              d_en_q;
  logic              v_sync_q;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              wide_q, wide_d;
  logic              narrow_q, narrow_d;
  logic [3:0]        err_q, err_d;
  logic              fall_s, rise_s, wide_eff_s, narrow_eff_s;
  logic [LCNT_W-1:0] lcnt_eff_s;
  logic [3:0]        terms_s;

  // A line ending in the frame-end cycle is folded into the ending frame.
  always_comb begin
    fall_s       = d_en_q & ~d_en_i;
    rise_s       = v_sync_i & ~v_sync_q;
    wide_eff_s   = wide_q | (fall_s & (wcnt_q > ACTIVE_WIDTH));
    narrow_eff_s = narrow_q | (fall_s & (wcnt_q < ACTIVE_WIDTH));
    if (fall_s && (lcnt_q != LCNT_MAX)) begin
      lcnt_eff_s = lcnt_q + 11'd1;
    end else begin
      lcnt_eff_s = lcnt_q;
    end
    terms_s = {wide_eff_s, narrow_eff_s, (lcnt_eff_s > LINE_NUM), (lcnt_eff_s < LINE_NUM)};

    if (fall_s) begin
      wcnt_d = '0;
    end else if (d_en_i && (wcnt_q != WCNT_MAX)) begin
      wcnt_d = wcnt_q + 12'd1;
    end else begin
      wcnt_d = wcnt_q;
    end

    if (rise_s) begin
      wide_d   = 1'b0;
      narrow_d = 1'b0;
      lcnt_d   = '0;
      err_d    = terms_s;
    end else begin
      wide_d   = wide_eff_s;
      narrow_d = narrow_eff_s;
      lcnt_d   = lcnt_eff_s;
      err_d    = err_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_en_q   <= 1'b0;
      v_sync_q <= 1'b0;
      wcnt_q   <= '0;
      lcnt_q   <= '0;
      wide_q   <= 1'b0;
      narrow_q <= 1'b0;
      err_q    <= 4'd0;
    end else begin
      d_en_q   <= d_en_i;
      v_sync_q <= v_sync_i;
      wcnt_q   <= wcnt_d;
      lcnt_q   <= lcnt_d;
      wide_q   <= wide_d;
      narrow_q <= narrow_d;
      err_q    <= err_d;
    end
  end

  assign frame_end_o      = rise_s;
  assign frame_good_o     = ~|terms_s;
  assign width_high_err_o = err_q[3];
  assign width_low_err_o  = err_q[2];
  assign line_high_err_o  = err_q[1];
  assign line_low_err_o   = err_q[0];

endmodule

// File: rtl/display_mode_sequencer.sv
// Chooses between live video and the fail-safe pattern based on debounced frame
// quality and a v_sync watchdog; the output mux switches only on frame boundaries.
module display_mode_sequencer
  import display_mode_sequencer_pkg::*;
#(
  parameter logic [WCNT_W-1:0] ACTIVE_WIDTH = 12'd1920,
  parameter logic [LCNT_W-1:0] LINE_NUM     = 11'd1080,
  parameter logic [FCNT_W-1:0] LOCK_FRAMES  = 4'd3,
  parameter logic [FCNT_W-1:0] FAIL_FRAMES  = 4'd2,
  parameter logic [WD_W-1:0]   TIMEOUT      = 24'd8000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_h_sync,
  input  logic       in_v_sync,
  input  logic       in_d_en,
  input  logic [7:0] in_data,
  input  logic       pg_h_sync,
  input  logic       pg_v_sync,
  input  logic       pg_d_en,
  input  logic [7:0] pg_data,
  output logic       pg_start,
  output logic       out_h_sync,
  output logic       out_v_sync,
  output logic       out_d_en,
  output logic [7:0] out_data,
  output logic       width_High_err,
  output logic       width_Low_err,
  output logic       Line_High_err,
  output logic       Line_Low_err,
  output logic       live,
  output logic [1:0] state
);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] good_cnt_q, good_cnt_d, good_upd_s;
  logic [FCNT_W-1:0] bad_cnt_q, bad_cnt_d, bad_upd_s;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pg_v_sync_q;
  logic [10:0]       mux_q, mux_d;
  logic              live_q, pg_start_q;
  logic              frame_end_s, frame_good_s;
  logic              timeout_s, lock_s, fail_s, pg_rise_s;

  frame_timing_meter #(
    .ACTIVE_WIDTH (ACTIVE_WIDTH),
    .LINE_NUM     (LINE_NUM)
  ) u_meter (
    .clk_i            (clock),
    .rst_i            (reset),
    .d_en_i           (in_d_en),
    .v_sync_i         (in_v_sync),
    .frame_end_o      (frame_end_s),
    .frame_good_o     (frame_good_s),
    .width_high_err_o (width_High_err),
    .width_low_err_o  (width_Low_err),
    .line_high_err_o  (Line_High_err),
    .line_low_err_o   (Line_Low_err)
  );

  // Frame debounce counters and v_sync watchdog.
  always_comb begin
    if (frame_end_s && frame_good_s) begin
      good_upd_s = (good_cnt_q != FCNT_MAX) ? good_cnt_q + 4'd1 : good_cnt_q;
      bad_upd_s  = '0;
    end else if (frame_end_s) begin
      good_upd_s = '0;
      bad_upd_s  = (bad_cnt_q != FCNT_MAX) ? bad_cnt_q + 4'd1 : bad_cnt_q;
    end else begin
      good_upd_s = good_cnt_q;
      bad_upd_s  = bad_cnt_q;
    end
    lock_s = frame_end_s & frame_good_s & (good_upd_s >= LOCK_FRAMES);
    fail_s = frame_end_s & ~frame_good_s & (bad_upd_s >= FAIL_FRAMES);

    if (frame_end_s) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 24'd1;
    end else begin
      wd_d = wd_q;
    end
    // Fires on the cycle the count reaches TIMEOUT, even if a frame ends then.
    timeout_s = (wd_q == (TIMEOUT - 24'd1));
    pg_rise_s = pg_v_sync & ~pg_v_sync_q;
  end

  // Next state, counter clear on transition, and registered output selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACQUIRE: begin
        if (timeout_s) begin
          state_d = ST_FS_WAIT;
        end else if (lock_s) begin
          state_d = ST_LIVE;
        end else begin
          state_d = ST_ACQUIRE;
        end
      end
      ST_LIVE: begin
        if (timeout_s || fail_s) begin
          state_d = ST_FS_WAIT;
        end else begin
          state_d = ST_LIVE;
        end
      end
      ST_FS_WAIT: begin
        if (pg_rise_s) begin
          state_d = ST_FAILSAFE;
        end else begin
          state_d = ST_FS_WAIT;
        end
      end
      ST_FAILSAFE: begin
        if (lock_s && !timeout_s) begin
          state_d = ST_LIVE;
        end else begin
          state_d = ST_FAILSAFE;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    if (state_d != state_q) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      good_cnt_d = good_upd_s;
      bad_cnt_d  = bad_upd_s;
    end

    case (state_d)
      ST_LIVE:     mux_d = {in_h_sync, in_v_sync, in_d_en, in_data};
      ST_FAILSAFE: mux_d = {pg_h_sync, pg_v_sync, pg_d_en, pg_data};
      default:     mux_d = 11'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACQUIRE;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      wd_q        <= '0;
      pg_v_sync_q <= 1'b0;
      mux_q       <= 11'd0;
      live_q      <= 1'b0;
      pg_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      wd_q        <= wd_d;
      pg_v_sync_q <= pg_v_sync;
      mux_q       <= mux_d;
      live_q      <= (state_d == ST_LIVE);
      pg_start_q  <= (state_d == ST_FS_WAIT) || (state_d == ST_FAILSAFE);
    end
  end

  assign out_h_sync = mux_q[10];
  assign out_v_sync = mux_q[9];
  assign out_d_en   = mux_q[8];
  assign out_data   = mux_q[7:0];
  assign live       = live_q;
  assign pg_start   = pg_start_q;
  assign state      = state_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed bench for display_mode_sequencer with a small 16x8 format.
module tb_display_mode_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_h_sync, in_v_sync, in_d_en;
  logic [7:0] in_data;
  logic       pg_h_sync, pg_v_sync, pg_d_en;
  logic [7:0] pg_data;
  logic       pg_start, out_h_sync, out_v_sync, out_d_en;
  logic [7:0] out_data;
  logic       width_High_err, width_Low_err, Line_High_err, Line_Low_err;
  logic       live;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  display_mode_sequencer #(
    .ACTIVE_WIDTH (12'd16),
    .LINE_NUM     (11'd8),
    .LOCK_FRAMES  (4'd2),
    .FAIL_FRAMES  (4'd2),
    .TIMEOUT      (24'd2000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_h_sync      (in_h_sync),
    .in_v_sync      (in_v_sync),
    .in_d_en        (in_d_en),
    .in_data        (in_data),
    .pg_h_sync      (pg_h_sync),
    .pg_v_sync      (pg_v_sync),
    .pg_d_en        (pg_d_en),
    .pg_data        (pg_data),
    .pg_start       (pg_start),
    .out_h_sync     (out_h_sync),
    .out_v_sync     (out_v_sync),
    .out_d_en       (out_d_en),
    .out_data       (out_data),
    .width_High_err (width_High_err),
    .width_Low_err  (width_Low_err),
    .Line_High_err  (Line_High_err),
    .Line_Low_err   (Line_Low_err),
    .live           (live),
    .state          (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_line(input int w, input bit blank);
    for (int i = 0; i < w; i++) begin
      in_d_en = 1'b1;
      in_data = 8'(i + 1);
      tick();
    end
    in_d_en = 1'b0;
    in_data = 8'd0;
    if (blank) begin
      in_h_sync = 1'b1;
      tick();
      tick();
      in_h_sync = 1'b0;
      tick();
      tick();
    end
  endtask

  // Line 2 uses odd_w; tight drops d_en of the last line in the v_sync cycle.
  task automatic drive_frame(input int w, input int lines, input int odd_w, input bit tight);
    for (int l = 0; l < lines; l++) begin
      drive_line((l == 2) ? odd_w : w, !(tight && (l == lines - 1)));
    end
    in_v_sync = 1'b1;
    in_data   = 8'hC3;
    tick();
    in_v_sync = 1'b0;
    in_data   = 8'd0;
  endtask

  task automatic check_errs(input string tag, input logic [3:0] exp);
    check(tag, {width_High_err, width_Low_err, Line_High_err, Line_Low_err}, exp);
  endtask

  task automatic pg_pulse();
    pg_v_sync = 1'b0;
    tick();
    pg_v_sync = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_h_sync = 1'b0; in_v_sync = 1'b0; in_d_en = 1'b0; in_data = 8'd0;
    pg_h_sync = 1'b0; pg_v_sync = 1'b0; pg_d_en = 1'b0; pg_data = 8'h5A;
    tick();
    tick();
    check("rst_state", state, 2'd0);
    check("rst_live", live, 1'b0);
    check("rst_pg_start", pg_start, 1'b0);
    check("rst_out", {out_h_sync, out_v_sync, out_d_en, out_data}, 11'd0);
    check_errs("rst_errs", 4'b0000);
    reset = 1'b0;

    // 1: lock onto two good frames
    drive_frame(16, 8, 16, 1'b0);
    check_errs("t1_errs_f1", 4'b0000);
    check("t1_state_f1", state, 2'd0);
    drive_frame(16, 8, 16, 1'b0);
    check("t1_state_f2", state, 2'd1);
    check("t1_live", live, 1'b1);
    check("t1_out_vs", out_v_sync, 1'b1);
    check("t1_out_data_switch", out_data, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      in_data   = 8'(8'hA0 + i);
      in_h_sync = i[0];
      tick();
      check("t1_lag_data", out_data, 8'(8'hA0 + i));
      check("t1_lag_hs", out_h_sync, i[0]);
    end
    in_h_sync = 1'b0;
    in_data   = 8'd0;

    // 2: two wide frames drop to fail-safe
    drive_frame(16, 8, 17, 1'b0);
    check_errs("t2_errs_b1", 4'b1000);
    check("t2_state_b1", state, 2'd1);
    drive_frame(16, 8, 17, 1'b0);
    check_errs("t2_errs_b2", 4'b1000);
    check("t2_state_b2", state, 2'd2);
    check("t2_pg_start", pg_start, 1'b1);
    check("t2_blank", {out_v_sync, out_data}, 9'd0);
    pg_v_sync = 1'b0;
    tick();
    check("t2_wait", state, 2'd2);
    pg_v_sync = 1'b1;
    pg_data   = 8'h66;
    tick();
    check("t2_state_fs", state, 2'd3);
    check("t2_pg_out", {out_v_sync, out_data}, {1'b1, 8'h66});
    check("t2_live_fs", live, 1'b0);
    pg_data = 8'h3C;
    tick();
    check("t2_pg_follow", out_data, 8'h3C);

    // 3: too many lines, then recovery
    drive_frame(16, 9, 16, 1'b0);
    check_errs("t3_errs_b1", 4'b0010);
    drive_frame(16, 9, 16, 1'b0);
    check_errs("t3_errs_b2", 4'b0010);
    check("t3_state_b2", state, 2'd3);
    drive_frame(16, 8, 16, 1'b0);
    check_errs("t3_errs_g1", 4'b0000);
    check("t3_state_g1", state, 2'd3);
    drive_frame(16, 8, 16, 1'b0);
    check("t3_state_g2", state, 2'd1);
    check("t3_pg_start", pg_start, 1'b0);

    // 4: watchdog fires exactly TIMEOUT cycles after the last frame end
    repeat (1999) tick();
    check("t4_state_1999", state, 2'd1);
    tick();
    check("t4_state_2000", state, 2'd2);
    check("t4_pg_start", pg_start, 1'b1);
    pg_pulse();
    check("t4_state_fs", state, 2'd3);
    drive_frame(16, 8, 16, 1'b0);
    drive_frame(16, 8, 16, 1'b0);
    check("t4_relive", state, 2'd1);

    // 5: alternating frames never leave live; short frames flag low errors
    drive_frame(16, 8, 16, 1'b0);
    check("t5_g1", state, 2'd1);
    drive_frame(15, 7, 15, 1'b0);
    check_errs("t5_errs_low", 4'b0101);
    check("t5_b1", state, 2'd1);
    drive_frame(16, 8, 16, 1'b0);
    check("t5_g2", state, 2'd1);
    drive_frame(15, 7, 15, 1'b0);
    check("t5_b2", state, 2'd1);
    drive_frame(16, 8, 16, 1'b1);
    check_errs("t5_errs_tight", 4'b0000);
    check("t5_tight_state", state, 2'd1);

    // 6: asynchronous reset in the middle of a fail-safe frame
    drive_frame(15, 7, 15, 1'b0);
    drive_frame(15, 7, 15, 1'b0);
    check("t6_wait", state, 2'd2);
    pg_pulse();
    check("t6_fs", state, 2'd3);
    drive_line(16, 1'b1);
    drive_line(16, 1'b1);
    drive_line(16, 1'b1);
    in_d_en = 1'b1;
    repeat (5) tick();
    #2;
    reset   = 1'b1;
    in_d_en = 1'b0;
    #1;
    check("t6_rst_state", state, 2'd0);
    check("t6_rst_out", {out_v_sync, out_data}, 9'd0);
    check("t6_rst_flags", {pg_start, live}, 2'b00);
    check_errs("t6_rst_errs", 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    drive_frame(16, 8, 16, 1'b0);
    check_errs("t6_errs_g1", 4'b0000);
    check("t6_state_g1", state, 2'd0);
    drive_frame(16, 8, 16, 1'b0);
    check("t6_state_g2", state, 2'd1);
    check("t6_live", live, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
